// File: rtl/dff_arbiter_pkg.sv
// dff_arb_pkg: shared constants for the round-robin write arbiter.
//   - default NREQ / WIDTH / MAX_HOLD values
//   - arbiter state encoding (legacy-compatible localparam constants)
//   - hold-counter width helper (the counter only exists with ARB_LOCK_EN)
package dff_arb_pkg;

    localparam int DEF_NREQ     = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAX_HOLD = 4;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE   = 2'd0;
    localparam arb_state_t ST_GRANT  = 2'd1;
    localparam arb_state_t ST_LOCKED = 2'd2;

    // The counter must be able to hold the value MAX_HOLD itself.
    function automatic int hold_cnt_width(input int max_hold);
        return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
    endfunction

    localparam int HOLD_CNT_W = hold_cnt_width(DEF_MAX_HOLD);

endpackage

// File: rtl/dff_arbiter_if.sv
// dff_arbiter_if: requester-side bus of the shared-register arbiter.
//   req   [NREQ]        per-requester write request (level)
//   lock  [NREQ]        per-requester grant-hold request
//   d     [NREQ*WIDTH]  packed write data, slice i belongs to requester i
//   gnt   [NREQ]        registered one-hot grant
//   q     [WIDTH]       shared register value
//   qbar  [WIDTH]       bitwise inverse of q
//   valid               q has been written since reset
// Modports: master = requesters, slave = arbiter.
interface dff_arbiter_if
    import dff_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [NREQ*WIDTH-1:0] d;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      qbar;
    logic                  valid;

    modport master (
        output req, lock, d,
        input  gnt, q, qbar, valid
    );

    modport slave (
        input  req, lock, d,
        output gnt, q, qbar, valid
    );

endinterface

// File: rtl/dff_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search.
//   req        [NREQ]   request vector
//   ptr        [PTR_W]  first index to consider (0..NREQ-1)
//   winner     [NREQ]   one-hot first asserted req at or after ptr, wrapping
//   winner_idx [PTR_W]  binary index of winner
//   any                 at least one req asserted
module rr_picker #(
    parameter int NREQ  = 4,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  winner,
    output logic [PTR_W-1:0] winner_idx,
    output logic             any
);

    int               idx;
    logic [PTR_W-1:0] idx_v;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        idx        = 0;
        idx_v      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_v = PTR_W'(idx);
            if (!any && req[idx_v]) begin
                any           = 1'b1;
                winner[idx_v] = 1'b1;
                winner_idx    = idx_v;
            end
        end
    end

endmodule

// File: rtl/dff_arbiter.sv
// dff_arbiter: round-robin arbitrated shared register.
// Requesters compete for a single WIDTH-bit register; the winner of each
// edge is registered into a one-hot gnt, and at the following edge the
// granted requester's data slice is written into q (if it still requests).
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   dff_arbiter_if.slave (req, lock, d in; gnt, q, qbar, valid out)
// Build option: define ARB_LOCK_EN to enable grant locking (lock inputs,
// LOCKED state and hold counter limited to MAX_HOLD grant cycles).
module dff_arbiter
    import dff_arb_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic         clk,
    input  logic         rst,
    dff_arbiter_if.slave bus
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t       state, state_n;
    logic [NREQ-1:0]  gnt, gnt_n;
    logic [PTR_W-1:0] gnt_idx, gnt_idx_n;
    logic [PTR_W-1:0] ptr, ptr_n, ptr_next;
    logic [WIDTH-1:0] q;
    logic             valid;

    logic [NREQ-1:0]  pick;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_any;

    logic             write_hit;
    logic [WIDTH-1:0] wr_data;

    rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req        (bus.req),
        .ptr        (ptr),
        .winner     (pick),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    assign ptr_next  = (pick_idx == PTR_W'(NREQ - 1)) ? '0 : pick_idx + PTR_W'(1);

    // A grant only writes if its requester is still asserting req.
    assign write_hit = (state != ST_IDLE) && |(gnt & bus.req);

    always_comb begin
        wr_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == PTR_W'(i)) begin
                wr_data = bus.d[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef ARB_LOCK_EN
    localparam int HOLD_W = hold_cnt_width(MAX_HOLD);

    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic              hold_keep;

    // hold_cnt counts grant cycles of the current owner, including the
    // first one, so the owner keeps gnt for at most MAX_HOLD cycles.
    assign hold_keep = write_hit && |(gnt & bus.lock) && (hold_cnt < HOLD_W'(MAX_HOLD));
`else
    logic [NREQ-1:0] unused_lock;
    assign unused_lock = bus.lock;
`endif

    always_comb begin
        gnt_n     = '0;
        gnt_idx_n = gnt_idx;
        ptr_n     = ptr;
        state_n   = ST_IDLE;
        if (pick_any) begin
            gnt_n     = pick;
            gnt_idx_n = pick_idx;
            ptr_n     = ptr_next;
            state_n   = ST_GRANT;
        end
`ifdef ARB_LOCK_EN
        // While locked ptr already points past the owner, so a forced
        // release naturally re-arbitrates starting at owner+1.
        hold_n = pick_any ? HOLD_W'(1) : '0;
        if (hold_keep) begin
            gnt_n     = gnt;
            gnt_idx_n = gnt_idx;
            ptr_n     = ptr;
            state_n   = ST_LOCKED;
            hold_n    = hold_cnt + HOLD_W'(1);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            ptr     <= '0;
            q       <= '0;
            valid   <= 1'b0;
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            gnt_idx <= gnt_idx_n;
            ptr     <= ptr_n;
            if (write_hit) begin
                q     <= wr_data;
                valid <= 1'b1;
            end
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_n;
        end
    end
`endif

    assign bus.gnt   = gnt;
    assign bus.q     = q;
    assign bus.qbar  = ~q;
    assign bus.valid = valid;

endmodule

// File: doc/dff_arbiter.md
DFF_ARBITER -- requirements
Module: dff_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, width of the shared register.
REQ-003 SHALL have parameter MAX_HOLD, default 4, maximum consecutive locked grant cycles (used only with ARB_LOCK_EN).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  NREQ  per-requester write request, level.
REQ-007 SHALL have port lock  input  NREQ  per-requester grant-hold request; ignored without ARB_LOCK_EN.
REQ-008 SHALL have port d  input  NREQ*WIDTH  packed write data; slice i belongs to requester i.
REQ-009 SHALL have port gnt  output  NREQ  registered one-hot grant; all-zero when idle.
REQ-010 SHALL have port q  output  WIDTH  shared register value.
REQ-011 SHALL have port qbar  output  WIDTH  bitwise inverse of q.
REQ-012 SHALL have port valid  output  1  high once q has been written since reset.

Function
REQ-013 SHALL implement states IDLE (gnt all-zero) and GRANT (gnt one-hot), plus LOCKED when ARB_LOCK_EN is defined.
REQ-014 SHALL arbitrate round-robin at every rising edge where no lock is held: winner = first asserted req at or after pointer ptr, searching upward and wrapping from NREQ-1 to 0.
REQ-015 SHALL register the winner into gnt at that edge: req-to-gnt latency 1 cycle; no req asserted -> gnt <= 0, state IDLE.
REQ-016 SHALL set ptr <= winner+1 modulo NREQ at each new grant; ptr unchanged when idle.
REQ-017 SHALL, at the edge ending a cycle with gnt[i]=1 and req[i]=1, load q <= d slice i and set valid <= 1; gnt-to-q latency 1 cycle.
REQ-018 SHALL discard a grant whose requester has dropped req by the write edge: q unchanged, no retry.
REQ-019 SHALL permit gnt to move to a different requester on consecutive cycles (one write per cycle maximum, no dead cycle).
REQ-020 SHALL drive qbar = ~q in every cycle, including reset.
REQ-021 SHALL, with all NREQ requesters asserted continuously from reset, grant in order 0,1,...,NREQ-1,0,...

Reset
REQ-022 SHALL, while rst=0, force gnt=0, q=0, qbar=all-ones, valid=0, ptr=0, hold counter=0, state IDLE, regardless of clk.
REQ-023 SHALL abort any in-flight grant on reset assertion: no write to q, no pending grant after release.
REQ-024 SHALL arbitrate on the first rising edge after rst deasserts, with requester 0 highest priority.

Configuration
REQ-025 SHALL compile the lock feature only when macro ARB_LOCK_EN is defined.
REQ-026 SHALL, with ARB_LOCK_EN: if gnt[i]=1, req[i]=1, lock[i]=1 at a write edge, keep gnt on i (state LOCKED, no re-arbitration, ptr unchanged) for at most MAX_HOLD consecutive grant cycles, then force re-arbitration with ptr=i+1.
REQ-027 SHALL, with ARB_LOCK_EN, release the lock and re-arbitrate normally at the edge where lock[i] or req[i] is low.
REQ-028 SHALL, without ARB_LOCK_EN, ignore lock entirely, omit LOCKED state and hold counter; every grant lasts exactly one cycle.

Structure
REQ-029 SHALL place the state enum, default NREQ/WIDTH/MAX_HOLD constants and hold-counter width in package dff_arb_pkg.
REQ-030 SHALL implement the combinational round-robin search (req, ptr -> one-hot winner, any) as sub-module rr_picker.

Verification
REQ-031 SHALL test reset: rst=0 mid-run with gnt=4'b0100 -> gnt=0, q=8'h00, qbar=8'hFF, valid=0 immediately; next pick favours requester 0.
REQ-032 SHALL test single requester: req=4'b0010, d[15:8]=8'hA5 -> gnt=4'b0010 one cycle later, q=8'hA5, qbar=8'h5A, valid=1 the cycle after.
REQ-033 SHALL test fairness: req=4'b1111 held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,... with q following each slice.
REQ-034 SHALL test dropped request: req[2] falls in the cycle gnt=4'b0100 -> q unchanged, gnt moves to next requester.
REQ-035 SHALL test lock with ARB_LOCK_EN: req=4'b0011, lock=4'b0001 held -> gnt=4'b0001 for exactly 4 cycles, then 4'b0010.
REQ-036 SHALL test lock without ARB_LOCK_EN: same stimulus -> gnt alternates 0001,0010 every cycle.
